// File: rtl/spi_tx_byte_feeder_if.sv
// Host-side enqueue port, status flags and the DIN/WE/RDY handshake toward the SPI serial block.
// The feeder uses the master modport; whatever drives it from the host/SPI side uses slave.
interface spi_tx_byte_feeder_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [7:0]      host_data;
    logic            host_wr;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic [7:0]      spi_din;
    logic            spi_we;
    logic            spi_rdy;
    logic            busy;
    logic            overflow;
    logic            timeout_err;
    logic            err_clr;

    modport master (
        input  host_data, host_wr, spi_rdy, err_clr,
        output full, empty, count, spi_din, spi_we, busy, overflow, timeout_err
    );

    modport slave (
        output host_data, host_wr, spi_rdy, err_clr,
        input  full, empty, count, spi_din, spi_we, busy, overflow, timeout_err
    );
endinterface

// File: rtl/spi_tx_byte_feeder.sv
// Byte FIFO feeding the SPI serial block one byte at a time, pacing each WE with the
// RDY high-then-low acknowledge, an optional idle gap and a bounded wait for RDY.
module spi_tx_byte_feeder #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_tx_byte_feeder_if.master bus
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned GW   = $clog2(GAP_CYCLES + 1) + 1;

    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
    localparam logic [TW-1:0]   TLast     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]   GLast     = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAssertWe,
        StWaitDone,
        StGap
    } state_e;

    state_e            state_q;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [CntW-1:0]   count_d;
    logic              full_q;
    logic              empty_q;
    logic [7:0]        din_q;
    logic              we_q;
    logic              overflow_q;
    logic              timeout_q;
    logic [TW-1:0]     tcnt_q;
    logic [GW-1:0]     gcnt_q;
    logic              push;
    logic              pop;

    always_comb begin
        push    = bus.host_wr && !full_q;
        pop     = (state_q == StLoad);
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Storage needs no reset: a reset clears the pointers, which discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.host_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            din_q      <= 8'h00;
            we_q       <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            tcnt_q     <= '0;
            gcnt_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == FullCount);
            empty_q <= (count_d == '0);

            if (bus.host_wr && full_q) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            // A timeout set further down overrides this clear in the same cycle.
            if (bus.err_clr) begin
                timeout_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (!empty_q) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    din_q   <= mem[rd_ptr_q];
                    we_q    <= 1'b1;
                    tcnt_q  <= '0;
                    state_q <= StAssertWe;
                end
                StAssertWe: begin
                    if (bus.spi_rdy) begin
                        // Drop WE right away so the SPI block cannot start a second write.
                        we_q    <= 1'b0;
                        state_q <= StWaitDone;
                    end else if (tcnt_q == TLast) begin
                        we_q      <= 1'b0;
                        timeout_q <= 1'b1;
                        gcnt_q    <= '0;
                        state_q   <= (GAP_CYCLES > 0) ? StGap : StIdle;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                StWaitDone: begin
                    if (!bus.spi_rdy) begin
                        gcnt_q  <= '0;
                        state_q <= (GAP_CYCLES > 0) ? StGap : StIdle;
                    end
                end
                StGap: begin
                    if (gcnt_q == GLast) begin
                        state_q <= StIdle;
                    end else begin
                        gcnt_q <= gcnt_q + GW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.count       = count_q;
    assign bus.spi_din     = din_q;
    assign bus.spi_we      = we_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_q;

endmodule
